// File: rtl/narnet_pkg.sv
// Shared constants and arithmetic helpers for the NAR-Net neuron datapath.
package narnet_pkg;

    localparam int N_DEF     = 10;
    localparam int Q_DEF     = 8;
    localparam int TAP_DEPTH = 17;

    // Clamp a wide signed value into the n-bit two's complement range.
    function automatic logic signed [31:0] sat_n(input logic signed [31:0] v, input int n);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (n - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (n - 1));
        if (v > hi) begin
            sat_n = hi;
        end else if (v < lo) begin
            sat_n = lo;
        end else begin
            sat_n = v;
        end
    endfunction

    // tanh table entry for raw index idx, rounded half away from zero; evaluated at elaboration only.
    function automatic logic signed [31:0] tanh_entry(input int idx, input int n, input int q);
        int  a;
        int  r;
        real v;
        a = (idx >= (32'sd1 <<< (n - 1))) ? idx - (32'sd1 <<< n) : idx;
        v = $tanh(real'(a) / real'(32'sd1 <<< q)) * real'(32'sd1 <<< q);
        if (v >= 0.0) begin
            r = $rtoi($floor(v + 0.5));
        end else begin
            r = -$rtoi($floor(-v + 0.5));
        end
        tanh_entry = sat_n(r, n);
    endfunction

endpackage

// File: rtl/narnet_tanh_rom.sv
// Registered tanh lookup: constant table indexed by the raw argument bits, one-cycle latency.
module narnet_tanh_rom
    import narnet_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        addr,
    output logic signed [N-1:0] data
);

    logic signed [N-1:0] rom_s [2**N];
    logic signed [N-1:0] data_r;

    for (genvar i = 0; i < 2**N; i++) begin : g_rom
        localparam logic signed [N-1:0] ENTRY = N'(tanh_entry(i, N, Q));
        assign rom_s[i] = ENTRY;
    end

    // Output register of the synchronous ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
        end else begin
            data_r <= rom_s[addr];
        end
    end

    assign data = data_r;

endmodule

// File: rtl/narnet_neuron_unit.sv
// One NAR-Net hidden neuron: saturating fixed-point MAC, tanh lookup and modulo-17 tap counter.
module narnet_neuron_unit
    import narnet_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int Q        = Q_DEF,
    parameter int TDC_INIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_load,
    input  logic                acc_en,
    input  logic signed [N-1:0] w,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] acc_out,
    input  logic signed [N-1:0] lut_addr,
    output logic signed [N-1:0] lut_out,
    input  logic                tdc_en,
    output logic [4:0]          tdc_count
);

    localparam int          PW       = 2 * N;
    localparam logic [4:0]  TAP_LAST = 5'(TAP_DEPTH - 1);
    // Out-of-range initial tap positions fall back to the buffer start.
    localparam logic [4:0]  TDC_RST  = (TDC_INIT < 0 || TDC_INIT > TAP_DEPTH - 1) ? 5'd0 : 5'(TDC_INIT);

    logic signed [N-1:0]  acc_r;
    logic signed [N-1:0]  acc_nxt_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] term_s;
    logic signed [31:0]   sum_s;
    logic [4:0]           tdc_r;
    logic [4:0]           tdc_nxt_s;

    // MAC next value: bias preload wins over accumulate; the sum is wide enough to never wrap before clamping.
    always_comb begin
        prod_s = PW'(w) * PW'(x);
        term_s = prod_s >>> Q;
        sum_s  = 32'(acc_r) + 32'(term_s);
        if (acc_load) begin
            acc_nxt_s = b;
        end else if (acc_en) begin
            acc_nxt_s = N'(sat_n(sum_s, N));
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Tap counter next value, wrapping after the last buffer slot.
    always_comb begin
        if (tdc_en) begin
            if (tdc_r >= TAP_LAST) begin
                tdc_nxt_s = 5'd0;
            end else begin
                tdc_nxt_s = tdc_r + 5'd1;
            end
        end else begin
            tdc_nxt_s = tdc_r;
        end
    end

    // Accumulator and tap counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            tdc_r <= TDC_RST;
        end else begin
            acc_r <= acc_nxt_s;
            tdc_r <= tdc_nxt_s;
        end
    end

    narnet_tanh_rom #(
        .N (N),
        .Q (Q)
    ) u_tanh_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (lut_addr),
        .data (lut_out)
    );

    assign acc_out   = acc_r;
    assign tdc_count = tdc_r;

endmodule

// File: tb/tb_narnet_neuron_unit.sv
// Directed self-checking bench for narnet_neuron_unit with N=10, Q=8, TDC_INIT=15.
module tb_narnet_neuron_unit;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_load;
    logic              acc_en;
    logic signed [9:0] w;
    logic signed [9:0] x;
    logic signed [9:0] b;
    logic signed [9:0] acc_out;
    logic signed [9:0] lut_addr;
    logic signed [9:0] lut_out;
    logic              tdc_en;
    logic [4:0]        tdc_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    narnet_neuron_unit #(
        .N        (10),
        .Q        (8),
        .TDC_INIT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_load  (acc_load),
        .acc_en    (acc_en),
        .w         (w),
        .x         (x),
        .b         (b),
        .acc_out   (acc_out),
        .lut_addr  (lut_addr),
        .lut_out   (lut_out),
        .tdc_en    (tdc_en),
        .tdc_count (tdc_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_probe(input int addr, input int exp);
        lut_addr = 10'(addr);
        tick();
        check($sformatf("lut_%0d", addr), int'(lut_out), exp);
    endtask

    initial begin
        rst = 1'b1; acc_load = 1'b0; acc_en = 1'b0;
        w = '0; x = '0; b = '0; lut_addr = 10'sd256; tdc_en = 1'b0;
        tick();
        check("rst_acc", int'(acc_out), 0);
        check("rst_lut", int'(lut_out), 0);
        check("rst_tdc", int'(tdc_count), 15);
        rst = 1'b0;

        // Bias preload and two MAC terms
        acc_load = 1'b1; b = 10'sd64;
        tick();
        check("bias_load", int'(acc_out), 64);
        acc_load = 1'b0; acc_en = 1'b1; w = 10'sd128; x = 10'sd192;
        tick();
        check("mac_pos", int'(acc_out), 160);
        w = -10'sd128;
        tick();
        check("mac_neg", int'(acc_out), 64);
        acc_en = 1'b0; w = 10'sd100;
        tick();
        check("acc_hold", int'(acc_out), 64);

        // Positive saturation
        acc_load = 1'b1; b = 10'sd0;
        tick();
        acc_load = 1'b0; acc_en = 1'b1; w = 10'sd511; x = 10'sd511;
        tick();
        check("sat_pos", int'(acc_out), 511);
        tick();
        check("sat_pos_hold", int'(acc_out), 511);
        acc_en = 1'b0;

        // Negative clamp with floor of a tiny negative product
        acc_load = 1'b1; b = -10'sd512;
        tick();
        check("bias_min", int'(acc_out), -512);
        acc_load = 1'b0; acc_en = 1'b1; w = -10'sd1; x = 10'sd1;
        tick();
        check("sat_neg", int'(acc_out), -512);

        // Floor on a negative product from zero: -1*1 >>> 8 = -1
        acc_en = 1'b0; acc_load = 1'b1; b = 10'sd0;
        tick();
        acc_load = 1'b0; acc_en = 1'b1;
        tick();
        check("floor_neg", int'(acc_out), -1);
        acc_en = 1'b0;

        // Load wins over accumulate
        acc_load = 1'b1; acc_en = 1'b1; b = 10'sd10; w = 10'sd511; x = 10'sd511;
        tick();
        check("load_priority", int'(acc_out), 10);
        acc_en = 1'b0;

        // tanh table, one-cycle latency
        lut_probe(0, 0);
        lut_probe(256, 195);
        lut_probe(-256, -195);
        lut_probe(511, 247);
        lut_probe(128, 118);
        lut_probe(-512, -247);
        lut_addr = 10'sd0;
        @(posedge clk);
        #1;
        lut_addr = 10'sd256;
        check("lut_latency", int'(lut_out), 0);
        tick();
        check("lut_latency_next", int'(lut_out), 195);

        // Tap counter wrap from 15; MAC and LUT active in the same cycles
        acc_load = 1'b0; acc_en = 1'b1; w = 10'sd32; x = 10'sd64;
        tdc_en = 1'b1;
        tick();
        check("tdc_16", int'(tdc_count), 16);
        check("concurrent_acc", int'(acc_out), 18);
        tick();
        check("tdc_wrap", int'(tdc_count), 0);
        tick();
        check("tdc_1", int'(tdc_count), 1);
        tdc_en = 1'b0; acc_en = 1'b0;
        tick();
        check("tdc_hold", int'(tdc_count), 1);

        // Reset during load discards everything
        rst = 1'b1; acc_load = 1'b1; b = 10'sd77; acc_en = 1'b1; tdc_en = 1'b1;
        tick();
        check("rst_over_load", int'(acc_out), 0);
        check("rst_tdc_again", int'(tdc_count), 15);
        check("rst_lut_again", int'(lut_out), 0);
        rst = 1'b0; acc_en = 1'b0; tdc_en = 1'b0;

        // Sixteen back-to-back terms of 8 after a zero bias
        acc_load = 1'b1; b = 10'sd0;
        tick();
        acc_load = 1'b0; acc_en = 1'b1; w = 10'sd32; x = 10'sd64;
        tick();
        check("b2b_first", int'(acc_out), 8);
        for (int i = 1; i < 16; i++) begin
            tick();
        end
        check("b2b_16", int'(acc_out), 128);
        acc_en = 1'b0;
        tick();
        check("b2b_hold", int'(acc_out), 128);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/narnet_neuron_unit.md
Name: narnet_neuron_unit

Overview:
- Arithmetic primitive group for the NAR-Net inference engine. It has three independent functions that share clk and rst:
  - a fixed-point multiply-accumulate neuron with bias preload;
  - a registered tanh lookup table;
  - a modulo-17 tap-delay address counter that walks the 17-entry circular sample buffer.
- The NAR-Net controller instantiates one unit per hidden neuron. It steers the weight, input and bias values and sequences the control signals.

Parameters:
- N, 10, total signed fixed-point width (two's complement).
- Q, 8, fractional bits. Value = raw / 2^Q.
- TDC_INIT, 0, value loaded into the tap counter on rst (legal range 0..16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high. Clears the accumulator, LUT output and counter as listed in Behaviour.
- acc_load  in  1  when high, the accumulator loads b (bias preload, neuron clear).
- acc_en  in  1  when high, accumulate w*x for one term.
- w  in  N  signed weight.
- x  in  N  signed input.
- b  in  N  signed bias.
- acc_out  out  N  signed accumulator value (registered).
- lut_addr  in  N  signed tanh argument.
- lut_out  out  N  signed tanh(lut_addr), registered.
- tdc_en  in  1  advance the tap counter.
- tdc_count  out  5  current buffer index, range 0..16.

Behaviour:
- Reset (rst=1), priority over everything else:
  - acc_out <= 0
  - lut_out <= 0
  - tdc_count <= TDC_INIT
- Neuron, priority order acc_load > acc_en > hold:
  - acc_load=1: acc_out <= b. acc_en is ignored in that cycle.
  - acc_en=1:
    - p = w*x as a full 2N-bit signed product.
    - t = p >>> Q (arithmetic shift, floor toward -inf).
    - s = acc_out + t, computed at least N+2 bits wide.
    - acc_out <= s, saturated to [-(2^(N-1)), 2^(N-1)-1].
  - Otherwise acc_out holds its value.
  - Latency: the term sampled at edge k is visible on acc_out after edge k.
  - acc_en may stay high on consecutive cycles; one term is added per cycle.
- tanh LUT:
  - Synchronous ROM, 2^N entries indexed by the raw bits of lut_addr.
  - lut_out <= entry one cycle after the address is presented.
  - Entry for raw value a: round-half-away-from-zero of tanh(a/2^Q)*2^Q, clamped to the N-bit signed range.
  - The table is odd-symmetric: entry(-a) = -entry(a), except a = -2^(N-1), which uses the clamp.
  - Contents are built at elaboration, by an initial block using real math or by $readmemh of a generated file. Both are allowed if the values match bit-exactly.
- Tap counter:
  - tdc_en=1: tdc_count <= (tdc_count==16) ? 0 : tdc_count+1.
  - Otherwise hold.
  - A TDC_INIT above 16 is illegal. The implementation forces such values to 0 at reset.
- The three functions are fully independent. Simultaneous activity on all three in one cycle is legal.
- Reset mid-accumulation discards the partial sum. The following acc_load restarts the neuron cleanly.

Decomposition:
- Shared package narnet_pkg holds:
  - defaults N_DEF=10, Q_DEF=8;
  - TAP_DEPTH=17;
  - the saturation helper function sat_n.
- Natural sub-module: narnet_tanh_rom (ROM array plus output register).
- The MAC and the counter stay inline in narnet_neuron_unit.

Test Plan:
1. Bias and MAC, N=10, Q=8:
   - acc_load with b=64 -> acc_out=64.
   - acc_en with w=128, x=192 -> acc_out=160.
   - A second acc_en with w=-128, x=192 -> acc_out=64.
2. Saturation and floor:
   - Positive: after acc_load b=0, acc_en w=511, x=511 -> acc_out=511. A further acc_en with the same inputs holds 511.
   - Negative: acc_load b=-512, then acc_en w=-1, x=1 -> t=-1, acc_out stays -512 (clamped).
3. Priority and reset:
   - acc_load=1 and acc_en=1 with b=10 -> acc_out=10.
   - rst=1 concurrent with acc_load -> acc_out=0.
4. tanh LUT, one-cycle latency:
   - addr 0 -> 0
   - addr 256 -> 195
   - addr -256 -> -195
   - addr 511 -> 247
   - addr 128 -> 118
5. Tap counter with TDC_INIT=15:
   - After rst: count=15.
   - tdc_en for 3 cycles -> 16, 0, 1.
   - tdc_en low -> holds 1.
   - rst -> 15.
6. Back-to-back acc_en for 16 cycles with w=32, x=64 (t=8 each), b=0 -> acc_out=128 after the 16th edge.
